fir_sched: RTL and testbench

Job scheduler that shares one `fir_multi_chan` core between `NUM_REQ` requesters. It round-robin grants the core to one requester at a time. For each job it issues a clean core reset, streams the requester's tap set and data frame into the core, forwards the core's results tagged with the requester ID, and signals completion. It sits between the requester-side stream sources and the core's `tap_i`/`data_i`/`result_*` ports.

---
 rtl/fir_pkg.sv | 23 ++
 rtl/fir_rr_arb.sv | 43 ++++
 rtl/fir_sched.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_fir_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: definitions shared by the fir_sched job scheduler and its arbiter.
//   fir_sched_state_e   : scheduler FSM states
//   FIR_CORE_FIFO_DEPTH : input FIFO depth of the shared fir_multi_chan core
//   fir_max()           : constant helper used for counter sizing
package fir_pkg;

  localparam int FIR_CORE_FIFO_DEPTH = 256;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    CLR   = 3'd2,
    TAPS  = 3'd3,
    DATA  = 3'd4,
    DRAIN = 3'd5,
    DONE  = 3'd6
  } fir_sched_state_e;

  function automatic int fir_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fir_rr_arb.sv
// fir_rr_arb: combinational round-robin pick.
//   req_i : request vector
//   ptr_i : index with highest priority this round
//   gnt_o : one-hot winner (zero when no request)
//   idx_o : winner index
//   vld_o : a winner exists
module fir_rr_arb
  import fir_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               vld_o
);

  int pos;

  // Scan from the farthest offset down to ptr so the nearest request wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    pos   = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      pos = int'(ptr_i) + off;
      pos = (pos >= NUM_REQ) ? (pos - NUM_REQ) : pos;
      if (req_i[pos]) begin
        gnt_o      = '0;
        gnt_o[pos] = 1'b1;
        idx_o      = IDX_W'(pos);
        vld_o      = 1'b1;
      end else begin
        // no request here: the pick from a farther offset stands
        vld_o = vld_o;
      end
    end
  end

endmodule

// File: rtl/fir_sched.sv
// fir_sched: shares one fir_multi_chan core between NUM_REQ requesters.
// Per job: round-robin grant, two-cycle core reset, NTAP tap beats, NDATA
// data beats, then wait for the core's finish pulse while forwarding results
// tagged with the granted requester ID.
// Ports:
//   clk, reset (sync, active high)
//   req_i / gnt_o                : level requests, one-hot grant held per job
//   src_data_i/src_vld_i/src_rdy_o : per-requester streams (taps in low bits)
//   core_rst_o, core_tap_*, core_data_*, core_result_* : core side
//   res_o/res_vld_o/res_id_o     : tagged results
//   done_o / err_o               : completion pulse / watchdog pulse
// Build option: define FIR_SCHED_TIMEOUT_EN to enable the DRAIN watchdog
// (TIMEOUT cycles); otherwise DRAIN waits forever and err_o is tied low.
module fir_sched
  import fir_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int TAP_ROW    = 3,
  parameter  int TAP_COL    = 3,
  parameter  int TAP_WIDTH  = 8,
  parameter  int DATA_ROW   = 16,
  parameter  int DATA_COL   = 16,
  parameter  int DATA_WIDTH = 16,
  parameter  int TIMEOUT    = 4096,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] src_data_i,
  input  logic [NUM_REQ-1:0]            src_vld_i,
  output logic [NUM_REQ-1:0]            src_rdy_o,
  output logic                          core_rst_o,
  output logic [TAP_WIDTH-1:0]          core_tap_o,
  output logic                          core_tap_vld_o,
  output logic [DATA_WIDTH-1:0]         core_data_o,
  output logic                          core_data_vld_o,
  input  logic [31:0]                   core_result_i,
  input  logic                          core_result_vld_i,
  input  logic                          core_result_finish_i,
  output logic [31:0]                   res_o,
  output logic                          res_vld_o,
  output logic [IDX_W-1:0]              res_id_o,
  output logic [NUM_REQ-1:0]            done_o,
  output logic                          err_o
);

  localparam int NTAP  = TAP_ROW * TAP_COL;
  localparam int NDATA = DATA_ROW * DATA_COL;
  localparam int CNT_W = $clog2(fir_max(NTAP, NDATA) + 1);

  // The core has no backpressure, so a frame must fit its input FIFO.
  if (NDATA > FIR_CORE_FIFO_DEPTH) begin : g_chk_fifo
    $error("fir_sched: frame larger than core FIFO");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_chk_nreq
    $error("fir_sched: NUM_REQ out of range");
  end
  if (DATA_WIDTH < TAP_WIDTH || TIMEOUT < 1) begin : g_chk_width
    $error("fir_sched: bad DATA_WIDTH/TIMEOUT");
  end

  fir_sched_state_e          state_q, state_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d, gid_q, gid_d;
  logic [NUM_REQ-1:0]        gnt_q, gnt_d, rdy_q, rdy_d, done_q, done_d;
  logic                      core_rst_q, core_rst_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [TAP_WIDTH-1:0]      tap_q, tap_d;
  logic                      tap_vld_q, tap_vld_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      data_vld_q, data_vld_d;
  logic [31:0]               res_q, res_d;
  logic                      res_vld_q, res_vld_d;

  logic [NUM_REQ-1:0]        arb_gnt;
  logic [IDX_W-1:0]          arb_idx;
  logic                      arb_vld;
  logic                      beat;
  logic [DATA_WIDTH-1:0]     src_sel;
  logic                      wd_expired;

  fir_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  // rdy_q is only ever non-zero at the granted index, so this is the handshake.
  assign beat    = |(src_vld_i & rdy_q);
  assign src_sel = src_data_i[gid_q*DATA_WIDTH +: DATA_WIDTH];

`ifdef FIR_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

  // Watchdog: counts cycles spent in DRAIN, raises err on expiry.
  always_comb begin
    wd_d  = (state_q == DRAIN) ? (wd_q + WD_W'(1)) : '0;
    err_d = (state_q == DRAIN) && !core_result_finish_i && wd_expired;
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign wd_expired = 1'b0;
  assign err_o      = 1'b0;
`endif

  // Next-state and registered-output logic for the job sequence.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gid_d      = gid_q;
    gnt_d      = gnt_q;
    rdy_d      = rdy_q;
    core_rst_d = 1'b0;
    cnt_d      = cnt_q;
    tap_d      = tap_q;
    tap_vld_d  = 1'b0;
    data_d     = data_q;
    data_vld_d = 1'b0;
    done_d     = '0;
    // results only pass while a job owns the core
    if (gnt_q != '0) begin
      res_d     = core_result_i;
      res_vld_d = core_result_vld_i;
    end else begin
      res_d     = res_q;
      res_vld_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = ARB;
        end else begin
          state_d = IDLE;
        end
      end
      ARB: begin
        if (arb_vld) begin
          state_d    = CLR;
          gid_d      = arb_idx;
          gnt_d      = arb_gnt;
          ptr_d      = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : (arb_idx + IDX_W'(1));
          core_rst_d = 1'b1;
          cnt_d      = '0;
        end else begin
          state_d = IDLE;  // request withdrawn before arbitration
        end
      end
      CLR: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = TAPS;
          cnt_d   = '0;
          rdy_d   = gnt_q;
        end else begin
          core_rst_d = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end
      TAPS: begin
        if (beat) begin
          tap_d     = src_sel[TAP_WIDTH-1:0];
          tap_vld_d = 1'b1;
          if (cnt_q == CNT_W'(NTAP - 1)) begin
            // ready drops for one cycle between phases
            state_d = DATA;
            cnt_d   = '0;
            rdy_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      DATA: begin
        if (beat) begin
          data_d     = src_sel;
          data_vld_d = 1'b1;
          if (cnt_q == CNT_W'(NDATA - 1)) begin
            state_d = DRAIN;
            cnt_d   = '0;
            rdy_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (rdy_q == '0) begin
          rdy_d = gnt_q;  // end of the inter-phase bubble
        end else begin
          cnt_d = cnt_q;
        end
      end
      DRAIN: begin
        if (core_result_finish_i) begin
          state_d = DONE;
          done_d  = gnt_q;
        end else if (wd_expired) begin
          state_d    = DONE;
          done_d     = gnt_q;
          core_rst_d = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        rdy_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gid_q      <= '0;
      gnt_q      <= '0;
      rdy_q      <= '0;
      core_rst_q <= 1'b1;
      cnt_q      <= '0;
      tap_q      <= '0;
      tap_vld_q  <= 1'b0;
      data_q     <= '0;
      data_vld_q <= 1'b0;
      res_q      <= '0;
      res_vld_q  <= 1'b0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gid_q      <= gid_d;
      gnt_q      <= gnt_d;
      rdy_q      <= rdy_d;
      core_rst_q <= core_rst_d;
      cnt_q      <= cnt_d;
      tap_q      <= tap_d;
      tap_vld_q  <= tap_vld_d;
      data_q     <= data_d;
      data_vld_q <= data_vld_d;
      res_q      <= res_d;
      res_vld_q  <= res_vld_d;
      done_q     <= done_d;
    end
  end

  assign gnt_o           = gnt_q;
  assign src_rdy_o       = rdy_q;
  assign core_rst_o      = core_rst_q;
  assign core_tap_o      = tap_q;
  assign core_tap_vld_o  = tap_vld_q;
  assign core_data_o     = data_q;
  assign core_data_vld_o = data_vld_q;
  assign res_o           = res_q;
  assign res_vld_o       = res_vld_q;
  assign res_id_o        = gid_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_fir_sched.sv
// Directed bench for fir_sched (4 requesters, 3x3 taps, 16x16 frame,
// TIMEOUT=64). Inputs are driven and outputs sampled 1 ns after posedge.
module tb_fir_sched;

  localparam int NR    = 4;
  localparam int TW    = 8;
  localparam int DW    = 16;
  localparam int NTAP  = 9;
  localparam int NDATA = 256;
  localparam int TOT   = NTAP + NDATA;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_i, gnt_o, src_vld_i, src_rdy_o, done_o;
  logic [NR*DW-1:0] src_data_i;
  logic          core_rst_o, core_tap_vld_o, core_data_vld_o;
  logic [TW-1:0] core_tap_o;
  logic [DW-1:0] core_data_o;
  logic [31:0]   core_result_i, res_o;
  logic          core_result_vld_i, core_result_finish_i, res_vld_o, err_o;
  logic [1:0]    res_id_o;

  int n_tests = 0;
  int n_fail  = 0;

  // core-side capture
  logic [TW-1:0] cap_tap [0:15];
  logic [DW-1:0] cap_data[0:511];
  int tap_n = 0;
  int data_n = 0;

  fir_sched #(
    .NUM_REQ(4), .TAP_ROW(3), .TAP_COL(3), .TAP_WIDTH(8),
    .DATA_ROW(16), .DATA_COL(16), .DATA_WIDTH(16), .TIMEOUT(64)
  ) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .gnt_o(gnt_o),
    .src_data_i(src_data_i), .src_vld_i(src_vld_i), .src_rdy_o(src_rdy_o),
    .core_rst_o(core_rst_o), .core_tap_o(core_tap_o), .core_tap_vld_o(core_tap_vld_o),
    .core_data_o(core_data_o), .core_data_vld_o(core_data_vld_o),
    .core_result_i(core_result_i), .core_result_vld_i(core_result_vld_i),
    .core_result_finish_i(core_result_finish_i),
    .res_o(res_o), .res_vld_o(res_vld_o), .res_id_o(res_id_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Record what the core would receive; a core reset clears the record.
  always @(posedge clk) begin
    if (core_rst_o) begin
      tap_n  <= 0;
      data_n <= 0;
    end else begin
      if (core_tap_vld_o && tap_n < 16) begin
        cap_tap[tap_n] <= core_tap_o;
        tap_n          <= tap_n + 1;
      end
      if (core_data_vld_o && data_n < 512) begin
        cap_data[data_n] <= core_data_o;
        data_n           <= data_n + 1;
      end
    end
  end

  function automatic logic [TW-1:0] tap_val(input int g, input int k);
    return TW'(k + 1 + 16 * g);
  endfunction

  function automatic logic [DW-1:0] data_val(input int g, input int k);
    return DW'(1000 * g + k);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req_i = '0; src_vld_i = '0; src_data_i = '0;
    core_result_i = '0; core_result_vld_i = 1'b0; core_result_finish_i = 1'b0;
    tick; tick;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_rdy", src_rdy_o, 0);
    chk("rst_core_rst", core_rst_o, 1);
    chk("rst_vld", {core_tap_vld_o, core_data_vld_o, res_vld_o}, 0);
    chk("rst_res", res_o, 0);
    chk("rst_res_id", res_id_o, 0);
    chk("rst_done_err", {done_o, err_o}, 0);
    reset = 1'b0;
    chk("core_rst_hold", core_rst_o, 1);
    tick;
    chk("core_rst_release", core_rst_o, 0);
  endtask

  task automatic wait_gnt(input int g);
    int n = 0;
    while (gnt_o == '0 && n < 10) begin
      tick;
      n++;
    end
    chk("grant", gnt_o, 32'(1) << g);
    chk("grant_id", res_id_o, g);
  endtask

  // Feed requester g until 'stop' beats are accepted; gap = % of idle cycles.
  task automatic stream(input int g, input int gap, input int stop);
    int k = 0;
    int cyc = 0;
    bit want, beat;
    while (k < stop && cyc < 3000) begin
      want = (gap == 0) ? 1'b1 : ($urandom_range(99) >= gap);
      src_vld_i[g] = want;
      src_data_i[g*DW +: DW] = (k < NTAP) ? {8'h00, tap_val(g, k)} : data_val(g, k - NTAP);
      beat = want && src_rdy_o[g];
      tick;
      cyc++;
      if (beat) begin
        k++;
        if (k == NTAP || k == TOT) chk("rdy_drop", src_rdy_o, 0);
      end
    end
    src_vld_i = '0;
    chk("stream_beats", k, stop);
  endtask

  task automatic check_stream(input int g);
    int bad = 0;
    chk("tap_count", tap_n, NTAP);
    chk("data_count", data_n, NDATA);
    for (int k = 0; k < NTAP; k++) if (cap_tap[k] !== tap_val(g, k)) bad++;
    for (int k = 0; k < NDATA; k++) if (cap_data[k] !== data_val(g, k)) bad++;
    chk("stream_order", bad, 0);
  endtask

  task automatic finish_job(input int g);
    core_result_i = 32'hA5A5_0000 | 32'(g);
    core_result_vld_i = 1'b1;
    tick;
    core_result_vld_i = 1'b0;
    chk("res_vld", res_vld_o, 1);
    chk("res_data", res_o, 32'hA5A5_0000 | 32'(g));
    chk("res_id", res_id_o, g);
    core_result_finish_i = 1'b1;
    tick;
    core_result_finish_i = 1'b0;
    chk("done_pulse", done_o, 32'(1) << g);
    tick;
    chk("done_clear", done_o, 0);
    chk("gnt_clear", gnt_o, 0);
  endtask

  initial begin
    int n;
    do_reset;

    // stray result in IDLE is dropped
    core_result_i = 32'hDEAD_BEEF;
    core_result_vld_i = 1'b1;
    tick;
    core_result_vld_i = 1'b0;
    chk("stray_vld", res_vld_o, 0);
    chk("stray_data", res_o, 0);

    // single job from requester 0 with exact timing
    req_i = 4'b0001;
    tick;
    chk("arb_no_gnt", gnt_o, 0);
    tick;
    chk("gnt_cycle2", gnt_o, 4'b0001);
    chk("clr1", core_rst_o, 1);
    req_i = '0;  // dropping the request mid-job is ignored
    tick;
    chk("clr2", core_rst_o, 1);
    chk("clr2_rdy", src_rdy_o, 0);
    tick;
    chk("clr_end", core_rst_o, 0);
    chk("taps_rdy", src_rdy_o, 4'b0001);
    stream(0, 0, TOT);
    tick;
    check_stream(0);
    finish_job(0);

    // round robin with all requesters holding their request
    do_reset;
    req_i = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_gnt(j % 4);
      stream(j % 4, 0, TOT);
      tick;
      check_stream(j % 4);
      finish_job(j % 4);
    end
    req_i = '0;

    // requester 2 with random gaps; others drive junk that must be ignored
    src_data_i = {4{16'hBEEF}};
    req_i = 4'b0100;
    wait_gnt(2);
    req_i = '0;
    src_vld_i = 4'b1011;
    stream(2, 50, TOT);
    tick;
    check_stream(2);
    finish_job(2);

    // core never finishes
    req_i = 4'b0010;
    wait_gnt(1);
    req_i = '0;
    stream(1, 0, TOT);
`ifdef FIR_SCHED_TIMEOUT_EN
    n = 0;
    while (!err_o && n < 200) begin
      tick;
      n++;
    end
    chk("wd_cycles", n, 64);
    chk("wd_core_rst", core_rst_o, 1);
    chk("wd_done", done_o, 4'b0010);
    tick;
    chk("wd_err_clear", err_o, 0);
    chk("wd_rst_clear", core_rst_o, 0);
    chk("wd_gnt_clear", gnt_o, 0);
`else
    n = 0;
    for (int c = 0; c < 100; c++) begin
      tick;
      if (done_o != '0 || err_o) n++;
    end
    chk("drain_no_exit", n, 0);
    chk("drain_gnt_held", gnt_o, 4'b0010);
    chk("drain_rdy", src_rdy_o, 0);
`endif

    // reset in the middle of the data phase
    do_reset;
    req_i = 4'b0001;
    wait_gnt(0);
    req_i = '0;
    stream(0, 0, NTAP + 100);
    reset = 1'b1;
    tick;
    chk("midrst_gnt", gnt_o, 0);
    chk("midrst_rdy", src_rdy_o, 0);
    chk("midrst_done", {done_o, err_o}, 0);
    chk("midrst_core_rst", core_rst_o, 1);
    reset = 1'b0;
    req_i = 4'b1001;  // pointer back at 0 picks requester 0, not 3
    wait_gnt(0);
    chk("post_rst_done", done_o, 0);
    req_i = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
